hm74_serial_decoder: RTL and testbench

// - Receives a serial stream of modified Hamming(7,4) codewords from the link that carries the encoder's output.
// - Codeword layout: {p0,p1,d3,p2,d2,d1,d0}, where:
//   - p0 = d3^d2^d0
//   - p1 = d3^d1^d0
//   - p2 = d2^d1^d0
// - Deserialises each codeword, corrects any single-bit error, and optionally packs nibble pairs into bytes.
// - Presents the result on a valid/ready interface to downstream consumers.

---
 rtl/hm74_serial_decoder.sv | 141 ++++++++++++++
 tb/tb_hm74_serial_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hm74_serial_decoder.sv
// hm74_serial_decoder
//   Deserialises modified Hamming(7,4) codewords {p0,p1,d3,p2,d2,d1,d0}
//   (MSB first), corrects single-bit errors and optionally packs two
//   nibbles into one byte (first nibble in [7:4]). Results leave through a
//   single-entry valid/ready output register; a beat that finds the
//   register full and not being drained is dropped and flags overflow.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   sync              frame align: clears bit counter and pending nibble
//   sdi, sdi_valid    serial bit and its qualifier
//   out_data/out_corr decoded byte/nibble and "some nibble was corrected"
//   out_valid/ready   output handshake
//   overflow          sticky dropped-beat flag
//   err_cnt           saturating corrected-codeword count
// Optional feature: define HM74_ERRCNT_EN to build the error counter;
// otherwise err_cnt is tied to 0.
module hm74_serial_decoder #(
    parameter int PACK  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             sdi,
    input  logic             sdi_valid,
    output logic [7:0]       out_data,
    output logic             out_corr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] err_cnt
);
    logic [2:0] bitcnt;
    logic [5:0] shift;
    logic [3:0] hold;
    logic       corr_hold;
    logic       hi_pend;

    logic       done;
    logic [6:0] cw;
    logic [6:0] flip;
    logic [6:0] fixed;
    logic [2:0] pos;
    logic [3:0] nib;
    logic       corr;
    logic       beat;
    logic [7:0] beat_data;
    logic       beat_corr;

    // sync takes precedence, so a bit arriving with sync never completes a word
    assign done = sdi_valid && !sync && (bitcnt == 3'd6);
    assign cw   = {shift, sdi};

    always_comb begin
        pos[0] = cw[6] ^ cw[4] ^ cw[2] ^ cw[0];
        pos[1] = cw[5] ^ cw[4] ^ cw[1] ^ cw[0];
        pos[2] = cw[3] ^ cw[2] ^ cw[1] ^ cw[0];
        flip   = '0;
        // syndrome value p names bit position p counted from the MSB (1-based)
        if (pos != 3'd0)
            flip[3'd7 - pos] = 1'b1;
        fixed = cw ^ flip;
        nib   = {fixed[4], fixed[2], fixed[1], fixed[0]};
        corr  = (pos != 3'd0);
    end

    always_comb begin
        if (PACK != 0) begin
            beat      = done && hi_pend;
            beat_data = {hold, nib};
            beat_corr = corr_hold | corr;
        end else begin
            beat      = done;
            beat_data = {4'h0, nib};
            beat_corr = corr;
        end
    end

    // deserialiser and nibble-pairing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt    <= '0;
            shift     <= '0;
            hold      <= '0;
            corr_hold <= 1'b0;
            hi_pend   <= 1'b0;
        end else begin
            if (sync) begin
                bitcnt  <= sdi_valid ? 3'd1 : 3'd0;
                hi_pend <= 1'b0;
                if (sdi_valid)
                    shift <= {5'd0, sdi};
            end else if (sdi_valid) begin
                bitcnt <= (bitcnt == 3'd6) ? 3'd0 : bitcnt + 3'd1;
                shift  <= {shift[4:0], sdi};
            end
            if (done && PACK != 0) begin
                if (hi_pend) begin
                    hi_pend <= 1'b0;
                end else begin
                    hold      <= nib;
                    corr_hold <= corr;
                    hi_pend   <= 1'b1;
                end
            end
        end
    end

    // single-entry output register; accepting and reloading in one cycle is allowed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_corr  <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (beat) begin
            if (!out_valid || out_ready) begin
                out_data  <= beat_data;
                out_corr  <= beat_corr;
                out_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef HM74_ERRCNT_EN
    // counts every corrected codeword, including ones whose beat is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (done && corr && err_cnt != {CNT_W{1'b1}})
            err_cnt <= err_cnt + 1'b1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hm74_serial_decoder.sv
// Scoreboard bench for hm74_serial_decoder. Two instances share the serial
// input: index 0 is PACK=1/CNT_W=8, index 1 is PACK=0/CNT_W=3. The driver
// feeds a reference model that decodes by nearest-codeword search and pushes
// expected beats; a negedge monitor pops and compares on each handshake.
module tb_hm74_serial_decoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       sdi;
    logic       sdi_valid;
    logic       rdy  [2];
    logic [7:0] od   [2];
    logic       oc   [2];
    logic       ov   [2];
    logic       ovf  [2];
    logic [7:0] err_a;
    logic [2:0] err_b;
    int         errv [2];

    int total = 0;
    int bad   = 0;

`ifdef HM74_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    always #5 clk = ~clk;

    hm74_serial_decoder #(.PACK(1), .CNT_W(8)) u_p1 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .sdi(sdi), .sdi_valid(sdi_valid),
        .out_data(od[0]), .out_corr(oc[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
        .overflow(ovf[0]), .err_cnt(err_a));

    hm74_serial_decoder #(.PACK(0), .CNT_W(3)) u_p0 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .sdi(sdi), .sdi_valid(sdi_valid),
        .out_data(od[1]), .out_corr(oc[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
        .overflow(ovf[1]), .err_cnt(err_b));

    always_comb begin
        errv[0] = int'(err_a);
        errv[1] = int'(err_b);
    end

    // reference model state
    int         mcnt;
    logic [6:0] macc;
    logic       hi_pend;
    logic [3:0] hold;
    logic       hold_c;
    logic       mvalid [2];
    logic       movf   [2];
    int         merr   [2];
    int         emax   [2] = '{255, 7};
    logic [8:0] expq   [2][$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3]^d[2]^d[0], d[3]^d[1]^d[0], d[3], d[2]^d[1]^d[0], d[2], d[1], d[0]};
    endfunction

    // nearest codeword; the code is perfect so exactly one lies within distance 1
    function automatic logic [4:0] dec(input logic [6:0] c);
        logic [6:0] e;
        for (int d = 0; d < 16; d++) begin
            e = enc(4'(d));
            if ($countones(e ^ c) <= 1)
                return {e != c, 4'(d)};
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        mcnt = 0; macc = '0; hi_pend = 1'b0; hold = '0; hold_c = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mvalid[d] = 1'b0; movf[d] = 1'b0; merr[d] = 0;
            expq[d].delete();
        end
    endtask

    task automatic model_edge(input logic s, input logic b, input logic v);
        logic [4:0] r;
        logic [8:0] bt [2];
        logic       hb [2];
        logic       done;
        done = v && !s && (mcnt == 6);
        for (int d = 0; d < 2; d++) begin
            hb[d] = 1'b0;
            bt[d] = '0;
        end
        if (done) begin
            r = dec({macc[5:0], b});
            for (int d = 0; d < 2; d++)
                if (ERRCNT && r[4] && merr[d] < emax[d])
                    merr[d]++;
            if (hi_pend) begin
                hb[0] = 1'b1;
                bt[0] = {r[4] | hold_c, hold, r[3:0]};
                hi_pend = 1'b0;
            end else begin
                hold = r[3:0]; hold_c = r[4]; hi_pend = 1'b1;
            end
            hb[1] = 1'b1;
            bt[1] = {r[4], 4'h0, r[3:0]};
        end
        if (s) begin
            mcnt = v ? 1 : 0;
            macc = {6'd0, b};
            hi_pend = 1'b0;
        end else if (v) begin
            mcnt = (mcnt == 6) ? 0 : mcnt + 1;
            macc = {macc[5:0], b};
        end
        for (int d = 0; d < 2; d++) begin
            if (hb[d]) begin
                if (!mvalid[d] || rdy[d]) begin
                    expq[d].push_back(bt[d]);
                    mvalid[d] = 1'b1;
                end else begin
                    movf[d] = 1'b1;
                end
            end else if (mvalid[d] && rdy[d]) begin
                mvalid[d] = 1'b0;
            end
        end
    endtask

    // monitor: mid-cycle, checks handshake-visible state and pops on transfer
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("valid[%0d]", d), int'(ov[d]), int'(mvalid[d]));
                chk($sformatf("overflow[%0d]", d), int'(ovf[d]), int'(movf[d]));
                chk($sformatf("err_cnt[%0d]", d), errv[d], merr[d]);
                if (ov[d] && rdy[d]) begin
                    if (expq[d].size() == 0) begin
                        chk($sformatf("unexpected_beat[%0d]", d), 1, 0);
                    end else begin
                        e = expq[d].pop_front();
                        chk($sformatf("data[%0d]", d), int'(od[d]), int'(e[7:0]));
                        chk($sformatf("corr[%0d]", d), int'(oc[d]), int'(e[8]));
                    end
                end
            end
        end
    end

    task automatic step(input logic s, input logic b, input logic v,
                        input logic r0, input logic r1);
        sync = s; sdi = b; sdi_valid = v; rdy[0] = r0; rdy[1] = r1;
        @(posedge clk);
        model_edge(s, b, v);
        #1;
    endtask

    task automatic send_word(input logic [6:0] w, input logic r0, input logic r1);
        for (int i = 6; i >= 0; i--)
            step(1'b0, w[i], 1'b1, r0, r1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_data[%0d]", d), int'(od[d]), 0);
            chk($sformatf("rst_corr[%0d]", d), int'(oc[d]), 0);
            chk($sformatf("rst_valid[%0d]", d), int'(ov[d]), 0);
            chk($sformatf("rst_ovf[%0d]", d), int'(ovf[d]), 0);
            chk($sformatf("rst_err[%0d]", d), errv[d], 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        sync = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; rdy[0] = 1'b1; rdy[1] = 1'b1;
        do_reset();

        // T1: data 5 then 6 pack into 8'h56, visible right after the 14th bit
        send_word(7'b0100101, 1'b1, 1'b1);
        chk("t1_no_beat_after_first", int'(ov[0]), 0);
        send_word(7'b1100110, 1'b1, 1'b1);
        chk("t1_valid", int'(ov[0]), 1);
        chk("t1_data", int'(od[0]), 8'h56);
        chk("t1_corr", int'(oc[0]), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // T2: single error on d3, then 0xF
        do_reset();
        send_word(7'b0110101, 1'b1, 1'b1);
        send_word(7'b1111111, 1'b1, 1'b1);
        chk("t2_data", int'(od[0]), 8'h5F);
        chk("t2_corr", int'(oc[0]), 1);
        chk("t2_err", errv[0], ERRCNT ? 1 : 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // T3: PACK=0 instance stalled, second and third beats dropped
        do_reset();
        send_word(7'b0000000, 1'b1, 1'b0);
        send_word(7'b0100101, 1'b1, 1'b0);
        chk("t3_hold_data", int'(od[1]), 8'h00);
        chk("t3_ovf", int'(ovf[1]), 1);
        send_word(7'b1111111, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_drained", int'(ov[1]), 0);

        // T4: garbage then sync carrying c[6] of 0100101
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 5; i >= 0; i--)
            step(1'b0, 1'((7'b0100101 >> i) & 7'd1), 1'b1, 1'b1, 1'b1);
        chk("t4_valid", int'(ov[1]), 1);
        chk("t4_data", int'(od[1]), 8'h05);

        // T5: reset mid-word, then a clean word
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        do_reset();
        send_word(7'b0100101, 1'b1, 1'b1);
        chk("t5_data", int'(od[1]), 8'h05);

        // T6: eight back-to-back words, consumer always ready
        do_reset();
        for (int i = 0; i < 8; i++)
            send_word(enc(4'($urandom_range(0, 15))), 1'b1, 1'b1);
        chk("t6_ovf", int'(ovf[0]), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // random traffic: gaps, occasional sync and reset, random backpressure
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0)
                do_reset();
            else if ($urandom_range(0, 2) == 0)
                // valid codeword with at most one flipped bit
                send_word(enc(4'($urandom_range(0, 15))) ^ (7'd1 << $urandom_range(0, 7)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            else
                step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        for (int n = 0; n < 4; n++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
